// File: rtl/ebpc_pkg.sv
// Shared widths for the EBPC encoder path.
// Word width and frame counter width used across stages.
package ebpc_pkg;

    localparam int unsigned DATA_W      = 16;
    localparam int unsigned FRAME_CNT_W = 24;

endpackage

// File: rtl/ebpc_stream_reg.sv
// One-entry valid/ready register.
// Accepts a new word whenever empty or being drained in the same cycle.
module ebpc_stream_reg #(
    parameter int unsigned W = 16
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         in_vld_i,
    input  logic [W-1:0] in_data_i,
    output logic         in_rdy_o,
    output logic         out_vld_o,
    output logic [W-1:0] out_data_o,
    input  logic         out_rdy_i
);

    logic         vld_q;
    logic [W-1:0] data_q;

    assign in_rdy_o   = !vld_q || out_rdy_i;
    assign out_vld_o  = vld_q;
    assign out_data_o = data_q;

    // Reload wins over drain so a same-cycle swap keeps the entry valid.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vld_q  <= 1'b0;
            data_q <= '0;
        end else if (in_vld_i && in_rdy_o) begin
            vld_q  <= 1'b1;
            data_q <= in_data_i;
        end else if (out_rdy_i) begin
            vld_q  <= 1'b0;
        end
    end

endmodule

// File: rtl/zrle_frame_ctrl.sv
// Frame sequencer feeding the zero-run-length encoder.
// Forks nonzero words to a side stream and reports the nonzero count.
module zrle_frame_ctrl
    import ebpc_pkg::*;
#(
    parameter int unsigned CNT_W = FRAME_CNT_W
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [CNT_W-1:0]  cfg_len_i,
    input  logic              cfg_vld_i,
    output logic              cfg_rdy_o,
    input  logic [DATA_W-1:0] data_i,
    input  logic              vld_i,
    output logic              rdy_o,
    output logic              zrle_is_one_o,
    output logic              zrle_flush_o,
    output logic              zrle_vld_o,
    input  logic              zrle_rdy_i,
    input  logic              zrle_idle_i,
    output logic [DATA_W-1:0] nz_data_o,
    output logic              nz_vld_o,
    input  logic              nz_rdy_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [CNT_W-1:0]  nnz_o
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_e;

    state_e             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   nnz_cnt_q;
    logic [CNT_W-1:0]   nnz_q;
    logic               run;
    logic               is_nz;
    logic               space;
    logic               pass;
    logic               accept;
    logic               nz_load;

    assign run     = (state_q == RUN);
    assign is_nz   = (data_i != '0);
    assign pass    = !is_nz || space;
    assign accept  = vld_i && rdy_o;
    assign nz_load = accept && is_nz;

    assign rdy_o         = run && zrle_rdy_i && pass;
    assign zrle_vld_o    = run && vld_i && pass;
    assign zrle_flush_o  = run && (cnt_q == '0);
    assign zrle_is_one_o = run && is_nz;

    assign cfg_rdy_o = (state_q == IDLE);
    assign busy_o    = (state_q != IDLE);
    assign done_o    = (state_q == DONE);
    assign nnz_o     = nnz_q;

    ebpc_stream_reg #(
        .W (DATA_W)
    ) u_nz_reg (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .in_vld_i   (nz_load),
        .in_data_i  (data_i),
        .in_rdy_o   (space),
        .out_vld_o  (nz_vld_o),
        .out_data_o (nz_data_o),
        .out_rdy_i  (nz_rdy_i)
    );

    // Frame sequencing: count words down, wait for drain, pulse done.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            nnz_cnt_q <= '0;
            nnz_q     <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (cfg_vld_i) begin
                        cnt_q     <= cfg_len_i;
                        nnz_cnt_q <= '0;
                        state_q   <= RUN;
                    end
                end
                RUN: begin
                    if (accept) begin
                        if (is_nz) begin
                            nnz_cnt_q <= nnz_cnt_q + CNT_W'(1);
                        end
                        if (cnt_q == '0) begin
                            state_q <= DRAIN;
                        end else begin
                            cnt_q <= cnt_q - CNT_W'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (zrle_idle_i && !nz_vld_o) begin
                        nnz_q   <= nnz_cnt_q;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_zrle_frame_ctrl.sv
// Self-checking bench for zrle_frame_ctrl.
// Directed frames plus random traffic against a behavioural frame model.
module tb_zrle_frame_ctrl;
    import ebpc_pkg::*;

    localparam int CW = FRAME_CNT_W;
    localparam int DW = DATA_W;

    localparam int P_IDLE  = 0;
    localparam int P_RUN   = 1;
    localparam int P_DRAIN = 2;
    localparam int P_DONE  = 3;

    logic          clk;
    logic          rst_ni;
    logic [CW-1:0] cfg_len_i;
    logic          cfg_vld_i;
    logic          cfg_rdy_o;
    logic [DW-1:0] data_i;
    logic          vld_i;
    logic          rdy_o;
    logic          zrle_is_one_o;
    logic          zrle_flush_o;
    logic          zrle_vld_o;
    logic          zrle_rdy_i;
    logic          zrle_idle_i;
    logic [DW-1:0] nz_data_o;
    logic          nz_vld_o;
    logic          nz_rdy_i;
    logic          busy_o;
    logic          done_o;
    logic [CW-1:0] nnz_o;

    zrle_frame_ctrl dut (
        .clk_i         (clk),
        .rst_ni        (rst_ni),
        .cfg_len_i     (cfg_len_i),
        .cfg_vld_i     (cfg_vld_i),
        .cfg_rdy_o     (cfg_rdy_o),
        .data_i        (data_i),
        .vld_i         (vld_i),
        .rdy_o         (rdy_o),
        .zrle_is_one_o (zrle_is_one_o),
        .zrle_flush_o  (zrle_flush_o),
        .zrle_vld_o    (zrle_vld_o),
        .zrle_rdy_i    (zrle_rdy_i),
        .zrle_idle_i   (zrle_idle_i),
        .nz_data_o     (nz_data_o),
        .nz_vld_o      (nz_vld_o),
        .nz_rdy_i      (nz_rdy_i),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .nnz_o         (nnz_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int            errors = 0;
    int            checks = 0;
    int            ph = P_IDLE;
    int            rem = 0;
    int            nnz_m = 0;
    int            nnz_hold = 0;
    int            n_acc = 0;
    bit            full_m = 1'b0;
    logic [DW-1:0] nzq[$];
    logic [DW-1:0] words[$];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // One cycle: drive at negedge, check, advance the frame model.
    task automatic step(input bit cv, input int clen, input bit v,
                        input logic [DW-1:0] d, input bit zr,
                        input bit nr, input bit idle);
        bit ok;
        bit erdy;
        bit acc;
        bit was_full;
        @(negedge clk);
        cfg_vld_i   = cv;
        cfg_len_i   = CW'(clen);
        vld_i       = v;
        data_i      = d;
        zrle_rdy_i  = zr;
        nz_rdy_i    = nr;
        zrle_idle_i = idle;
        #1;
        ok   = (d == '0) || !full_m || nr;
        erdy = (ph == P_RUN) && zr && ok;
        chk("cfg_rdy", 32'(cfg_rdy_o), 32'(ph == P_IDLE));
        chk("busy", 32'(busy_o), 32'(ph != P_IDLE));
        chk("done", 32'(done_o), 32'(ph == P_DONE));
        chk("rdy", 32'(rdy_o), 32'(erdy));
        chk("zvld", 32'(zrle_vld_o), 32'((ph == P_RUN) && v && ok));
        chk("flush", 32'(zrle_flush_o),
            32'((ph == P_RUN) && (rem == 0)));
        if (ph == P_RUN && v)
            chk("is_one", 32'(zrle_is_one_o), 32'(d != '0));
        chk("nz_vld", 32'(nz_vld_o), 32'(full_m));
        if (full_m && nr && nzq.size() > 0)
            chk("nz_data", 32'(nz_data_o), 32'(nzq.pop_front()));
        chk("nnz_hold", 32'(nnz_o), 32'(nnz_hold));
        acc      = v && erdy;
        was_full = full_m;
        if (full_m && nr) full_m = 1'b0;
        case (ph)
            P_IDLE: if (cv) begin
                rem   = clen;
                nnz_m = 0;
                ph    = P_RUN;
            end
            P_RUN: if (acc) begin
                n_acc++;
                if (d != '0) begin
                    nzq.push_back(d);
                    full_m = 1'b1;
                    nnz_m++;
                end
                if (rem == 0) ph = P_DRAIN;
                else rem--;
            end
            P_DRAIN: if (idle && !was_full) begin
                nnz_hold = nnz_m;
                ph       = P_DONE;
            end
            default: ph = P_IDLE;
        endcase
    endtask

    task automatic fill(input int len, input bit all_nz);
        words.delete();
        for (int i = 0; i <= len; i++) begin
            if (all_nz)
                words.push_back(DW'($urandom_range(1, 65535)));
            else if ($urandom_range(0, 1) == 0)
                words.push_back('0);
            else
                words.push_back(DW'($urandom_range(1, 65535)));
        end
    endtask

    // zmode: 0 ready, 2 random, 3 stall window. nmode: 0 ready, 1 toggle, 2 random.
    task automatic do_frame(input int len, input int zmode,
                            input int nmode, input int stop_at);
        int cyc = 0;
        int dcyc = 0;
        int exp_nnz = 0;
        bit zr;
        bit nr;
        bit v;
        for (int i = 0; i <= len; i++)
            if (words[i] != '0) exp_nnz++;
        n_acc = 0;
        step(1'b1, len, 1'b0, '0, 1'b1, 1'b1, 1'b0);
        while (ph == P_RUN && cyc < 500) begin
            if (stop_at >= 0 && n_acc == stop_at) return;
            zr = 1'b1;
            if (zmode == 2) zr = ($urandom_range(0, 3) != 0);
            if (zmode == 3) zr = !(cyc >= 2 && cyc < 7);
            nr = 1'b1;
            if (nmode == 1) nr = (cyc % 2 == 0);
            if (nmode == 2) nr = ($urandom_range(0, 1) != 0);
            v = (zmode == 2) ? ($urandom_range(0, 3) != 0) : 1'b1;
            step(1'b0, 0, v, words[n_acc], zr, nr, 1'b0);
            cyc++;
        end
        chk("run_bound", 32'(cyc < 500), 32'(1));
        while (ph == P_DRAIN && dcyc < 50) begin
            nr = (nmode == 0) ? 1'b1 : ($urandom_range(0, 1) != 0);
            step(1'b0, 0, 1'b1, DW'($urandom_range(1, 65535)), 1'b1,
                 nr, dcyc >= 3);
            dcyc++;
        end
        chk("drain_bound", 32'(dcyc < 50), 32'(1));
        step(1'b0, 0, 1'b0, '0, 1'b1, 1'b1, 1'b1);
        chk("nnz_frame", 32'(nnz_o), 32'(exp_nnz));
        chk("nzq_empty", 32'(nzq.size()), 32'(0));
    endtask

    task automatic check_reset_vals();
        chk("rst_cfg_rdy", 32'(cfg_rdy_o), 32'(1));
        chk("rst_rdy", 32'(rdy_o), 32'(0));
        chk("rst_zvld", 32'(zrle_vld_o), 32'(0));
        chk("rst_flush", 32'(zrle_flush_o), 32'(0));
        chk("rst_is_one", 32'(zrle_is_one_o), 32'(0));
        chk("rst_nz_vld", 32'(nz_vld_o), 32'(0));
        chk("rst_nz_data", 32'(nz_data_o), 32'(0));
        chk("rst_busy", 32'(busy_o), 32'(0));
        chk("rst_done", 32'(done_o), 32'(0));
        chk("rst_nnz", 32'(nnz_o), 32'(0));
    endtask

    initial begin
        rst_ni      = 1'b0;
        cfg_len_i   = '0;
        cfg_vld_i   = 1'b0;
        data_i      = 16'h1234;
        vld_i       = 1'b1;
        zrle_rdy_i  = 1'b1;
        zrle_idle_i = 1'b0;
        nz_rdy_i    = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_vals();
        rst_ni = 1'b1;

        words.delete();
        words.push_back(16'h0);
        words.push_back(16'h5);
        words.push_back(16'h0);
        words.push_back(16'h7);
        do_frame(3, 0, 0, -1);

        words.delete();
        words.push_back(16'h0);
        do_frame(0, 0, 0, -1);

        fill(7, 1'b1);
        do_frame(7, 0, 1, -1);

        fill(9, 1'b0);
        do_frame(9, 3, 0, -1);

        fill(5, 1'b1);
        do_frame(5, 0, 0, 2);
        @(negedge clk);
        vld_i      = 1'b1;
        data_i     = 16'hbeef;
        zrle_rdy_i = 1'b1;
        nz_rdy_i   = 1'b0;
        #2;
        rst_ni = 1'b0;
        #1;
        check_reset_vals();
        ph       = P_IDLE;
        full_m   = 1'b0;
        nnz_hold = 0;
        nzq.delete();
        #1;
        rst_ni = 1'b1;

        words.delete();
        words.push_back(16'h9);
        words.push_back(16'h0);
        do_frame(1, 0, 0, -1);

        fill(1, 1'b1);
        do_frame(1, 0, 2, -1);
        fill(2, 1'b0);
        do_frame(2, 0, 2, -1);

        for (int f = 0; f < 4; f++) begin
            int len;
            len = int'($urandom_range(0, 12));
            fill(len, 1'b0);
            do_frame(len, 2, 2, -1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
